// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch PC register for the 64-bit LEGv8/ARMv8-style pipeline.
// Each cycle the PC either advances by PC_INC or loads a branch target; reset has priority.
// imem_addr_F is driven straight from the PC register, so no input reaches it combinationally.
// Optional build macro FETCH_ALIGN_EN: word-aligns the branch target and RESET_PC
// by clearing their low two bits. The sequential increment path is unchanged either way.
module fetch_stage #(
    parameter int unsigned    N        = 64,
    parameter logic [N-1:0]   RESET_PC = '0,
    parameter int unsigned    PC_INC   = 4
) (
    input  logic         PCSrc_F,
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] PCBranch_F,
    output logic [N-1:0] imem_addr_F
);

    logic [N-1:0] pc_q;
    logic [N-1:0] pc_d;
    logic [N-1:0] branch_tgt;
    logic [N-1:0] reset_val;

`ifdef FETCH_ALIGN_EN
    localparam logic [N-1:0] ALIGN_MASK = ~(N'(3));
    assign branch_tgt = PCBranch_F & ALIGN_MASK;
    assign reset_val  = RESET_PC & ALIGN_MASK;
`else
    assign branch_tgt = PCBranch_F;
    assign reset_val  = RESET_PC;
`endif

    // Next-PC selection: reset, then branch target, then sequential (wraps modulo 2^N)
    always_comb begin
        pc_d = pc_q + N'(PC_INC);
        if (reset) begin
            pc_d = reset_val;
        end else if (PCSrc_F) begin
            pc_d = branch_tgt;
        end
    end

    // PC register; reset is folded into pc_d so it is sampled synchronously
    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    assign imem_addr_F = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven directed vectors, hand-written between-edge sequences,
// and randomized stimulus checked against a behavioural PC model.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        PCSrc_F;
    logic [63:0] PCBranch_F;
    logic [63:0] imem_addr_F;

    int unsigned checks;
    int unsigned failures;

    fetch_stage #(
        .N        (64),
        .RESET_PC (64'h0),
        .PC_INC   (4)
    ) dut (
        .PCSrc_F     (PCSrc_F),
        .clk         (clk),
        .reset       (reset),
        .PCBranch_F  (PCBranch_F),
        .imem_addr_F (imem_addr_F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        src;
        logic [63:0] br;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] al(input logic [63:0] a);
`ifdef FETCH_ALIGN_EN
        return a & ~64'd3;
`else
        return a;
`endif
    endfunction

    function automatic vec_t mk(input logic r, input logic s, input logic [63:0] b,
                                input logic [63:0] e, input string n);
        vec_t v;
        v.rst = r; v.src = s; v.br = b; v.exp = e; v.name = n;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, sample 1 time unit later
    task automatic step(input logic r, input logic s, input logic [63:0] b);
        reset = r; PCSrc_F = s; PCBranch_F = b;
        @(posedge clk);
        #1;
    endtask

    logic [63:0] model_pc;
    logic [63:0] held;

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1; PCSrc_F = 1'b0; PCBranch_F = '0;

        vecs.push_back(mk(1, 0, 64'h0,   64'h0,     "reset_0"));
        vecs.push_back(mk(1, 0, 64'h0,   64'h0,     "reset_1"));
        vecs.push_back(mk(1, 0, 64'h0,   64'h0,     "reset_2"));
        vecs.push_back(mk(0, 0, 64'h0,   64'h4,     "seq_4"));
        vecs.push_back(mk(0, 0, 64'h0,   64'h8,     "seq_8"));
        vecs.push_back(mk(0, 1, 64'h5,   al(64'h5), "branch_5"));
        vecs.push_back(mk(0, 1, 64'hF,   al(64'hF), "branch_hold_15"));
        vecs.push_back(mk(0, 1, 64'h100, 64'h100,   "branch_100"));
        vecs.push_back(mk(0, 0, 64'h0,   64'h104,   "seq_104"));
        vecs.push_back(mk(0, 0, 64'h0,   64'h108,   "seq_108"));
        vecs.push_back(mk(1, 1, 64'h40,  64'h0,     "reset_beats_branch"));
        vecs.push_back(mk(0, 0, 64'h40,  64'h4,     "resume_after_reset"));
        vecs.push_back(mk(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, "branch_top"));
        vecs.push_back(mk(0, 0, 64'h0,   64'h0,     "wrap_to_0"));
        vecs.push_back(mk(0, 0, 64'h0,   64'h4,     "after_wrap"));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].src, vecs[i].br);
            chk(vecs[i].name, imem_addr_F, vecs[i].exp);
        end

        // Between-edge toggling of PCBranch_F with PCSrc_F=0: output moves only at edges
        held = imem_addr_F;
        PCSrc_F = 1'b0;
        for (int k = 0; k < 3; k++) begin
            PCBranch_F = {$urandom, $urandom};
            #2;
            chk("midcycle_branch_toggle", imem_addr_F, held);
        end
        @(posedge clk); #1;
        chk("seq_after_toggle", imem_addr_F, held + 64'd4);

        // PCSrc_F pulsed high between edges but low at the edge: no branch taken
        held = imem_addr_F;
        PCSrc_F = 1'b1; PCBranch_F = 64'h800;
        #2;
        chk("midcycle_src_pulse", imem_addr_F, held);
        PCSrc_F = 1'b0;
        @(posedge clk); #1;
        chk("src_pulse_ignored", imem_addr_F, held + 64'd4);

        // Misaligned branch then sequential continues from the loaded value
        step(0, 1, 64'h1003);
        chk("misaligned_load", imem_addr_F, al(64'h1003));
        step(0, 0, 64'h0);
        chk("misaligned_seq", imem_addr_F, al(64'h1003) + 64'd4);

        // Randomized run against a behavioural model; starts from a reset edge
        model_pc = 64'h0;
        step(1, 0, 64'h0);
        chk("rand_start_reset", imem_addr_F, model_pc);
        for (int n = 0; n < 300; n++) begin
            logic        r;
            logic        s;
            logic [63:0] b;
            r = ($urandom_range(0, 15) == 0);
            s = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 2))
                0:       b = {$urandom, $urandom};
                1:       b = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                default: b = 64'($urandom_range(0, 255));
            endcase
            if (r)      model_pc = 64'h0;
            else if (s) model_pc = al(b);
            else        model_pc = model_pc + 64'd4;
            step(r, s, b);
            chk("random", imem_addr_F, model_pc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
